part_univ_reg: RTL and testbench



---
 rtl/part_univ_reg.sv | 86 ++++++++
 tb/tb_part_univ_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/part_univ_reg.sv
// Generic WIDTH-bit shift/count/load register with cascade enable and terminal count.
// Optional registered even parity on PAR is enabled by defining PART_UNIV_REG_PARITY_EN.
module part_univ_reg #(
  parameter int          WIDTH     = 6,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [2:0]       MODE,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             SR,
  input  logic             SL,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             PAR
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONES  = '1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_UP   = 3'b100;
  localparam logic [2:0] M_DOWN = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc;

  // Sync clear bypasses EN so a stalled cascade can still be zeroed.
  always_comb begin
    w_q_nxt = r_q;
    if (MODE == M_CLR) begin
      w_q_nxt = ZERO;
    end else if (EN) begin
      case (MODE)
        M_HOLD:  w_q_nxt = r_q;
        M_SHR:   w_q_nxt = {SR, r_q[WIDTH-1:1]};
        M_SHL:   w_q_nxt = {r_q[WIDTH-2:0], SL};
        M_LOAD:  w_q_nxt = D;
        M_UP:    w_q_nxt = r_q + ONE;
        M_DOWN:  w_q_nxt = r_q - ONE;
        M_ROR:   w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
        default: w_q_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_q <= RST_Q;
    else     r_q <= w_q_nxt;
  end

  always_comb begin
    w_tc = 1'b0;
    if (!CLR && EN) begin
      if (MODE == M_UP)   w_tc = (r_q == ONES);
      if (MODE == M_DOWN) w_tc = (r_q == ZERO);
    end
  end

  assign Q  = r_q;
  assign TC = w_tc;

`ifdef PART_UNIV_REG_PARITY_EN
  logic r_par;

  // Parity is computed from the next value so it lines up with Q after the edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_par <= ^RST_Q;
    else     r_par <= ^w_q_nxt;
  end

  assign PAR = r_par;
`else
  assign PAR = 1'b0;
`endif

endmodule

// File: tb/tb_part_univ_reg.sv
// Directed-vector bench for part_univ_reg: reset, load, shifts, count wrap,
// enable gating, two-stage cascade and asynchronous reset mid-operation.
module tb_part_univ_reg;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_a, clr_b;
  logic [2:0] mode;
  logic       en, sr, sl;
  logic [5:0] d6;

  logic [5:0] q_a, q_b;
  logic       tc_a, tc_b, par_a, par_b;

  logic [2:0] c_mode;
  logic [7:0] c_d;
  logic       c_ld;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, par_lo, par_hi;
  logic       w_en_hi;

  assign w_en_hi = c_ld | tc_lo;

  int n_vec = 0;
  int n_err = 0;

  part_univ_reg #(.WIDTH(6), .RESET_VAL(32'h00)) u_a (
    .CLK(clk), .CLR(clr_a), .MODE(mode), .EN(en), .D(d6), .SR(sr), .SL(sl),
    .Q(q_a), .TC(tc_a), .PAR(par_a)
  );

  part_univ_reg #(.WIDTH(6), .RESET_VAL(32'h15)) u_b (
    .CLK(clk), .CLR(clr_b), .MODE(mode), .EN(en), .D(d6), .SR(sr), .SL(sl),
    .Q(q_b), .TC(tc_b), .PAR(par_b)
  );

  part_univ_reg #(.WIDTH(4), .RESET_VAL(32'h0)) u_lo (
    .CLK(clk), .CLR(clr_a), .MODE(c_mode), .EN(1'b1), .D(c_d[3:0]), .SR(1'b0), .SL(1'b0),
    .Q(q_lo), .TC(tc_lo), .PAR(par_lo)
  );

  part_univ_reg #(.WIDTH(4), .RESET_VAL(32'h0)) u_hi (
    .CLK(clk), .CLR(clr_a), .MODE(c_mode), .EN(w_en_hi), .D(c_d[7:4]), .SR(1'b0), .SL(1'b0),
    .Q(q_hi), .TC(tc_hi), .PAR(par_hi)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [5:0] v);
`ifdef PART_UNIV_REG_PARITY_EN
    return ^v;
`else
    return 1'b0;
`endif
  endfunction

  // driver: one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [5:0] v);
    mode = 3'b011; d6 = v; en = 1'b1;
    step();
  endtask

  task automatic check_a(input string tag, input logic [5:0] exp_q, input logic exp_tc);
    check({tag, "_q"},   {26'd0, q_a}, {26'd0, exp_q});
    check({tag, "_tc"},  {31'd0, tc_a}, {31'd0, exp_tc});
    check({tag, "_par"}, {31'd0, par_a}, {31'd0, exp_par(exp_q)});
  endtask

  initial begin
    clr_a = 1'b1; clr_b = 1'b1;
    mode = 3'b000; en = 1'b1; sr = 1'b0; sl = 1'b0; d6 = 6'h00;
    c_mode = 3'b000; c_d = 8'h00; c_ld = 1'b0;
    repeat (2) step();
    check_a("reset", 6'h00, 1'b0);
    check("reset_b_q", {26'd0, q_b}, 32'h15);

    // reset asserted mid-cycle acts immediately and holds through an edge
    clr_a = 1'b0;
    load_a(6'h3F);
    check_a("load_3f", 6'h3F, 1'b0);
    #3 clr_a = 1'b1;
    #1 check("clr_async_q", {26'd0, q_a}, 32'h00);
    step();
    check_a("clr_hold", 6'h00, 1'b0);
    clr_a = 1'b0;

    load_a(6'h2A);
    check_a("load_2a", 6'h2A, 1'b0);

    // shifts and rotate
    mode = 3'b001; sr = 1'b1; step();
    check_a("shr", 6'h35, 1'b0);
    mode = 3'b010; sl = 1'b0; step();
    check_a("shl", 6'h2A, 1'b0);
    mode = 3'b110; sr = 1'b1; step();
    check_a("ror", 6'h15, 1'b0);

    // count wrap up and down
    load_a(6'h3E);
    mode = 3'b100; #1;
    check("up_tc_pre", {31'd0, tc_a}, 32'd0);
    step();
    check_a("up_3f", 6'h3F, 1'b1);
    step();
    check_a("up_wrap", 6'h00, 1'b0);
    mode = 3'b101; #1;
    check("dn_tc_at0", {31'd0, tc_a}, 32'd1);
    step();
    check_a("dn_wrap", 6'h3F, 1'b0);

    // enable gating
    load_a(6'h10);
    en = 1'b0; mode = 3'b100; #1;
    check("en0_tc", {31'd0, tc_a}, 32'd0);
    step();
    check_a("en0_hold", 6'h10, 1'b0);
    mode = 3'b111; step();
    check_a("en0_sclr", 6'h00, 1'b0);
    en = 1'b1;

    // two 4-bit stages cascaded through TC -> EN
    c_ld = 1'b1; c_mode = 3'b011; c_d = 8'h0F; step();
    check("cas_load", {24'd0, q_hi, q_lo}, 32'h0F);
    c_ld = 1'b0; c_mode = 3'b100; step();
    check("cas_0f_10", {24'd0, q_hi, q_lo}, 32'h10);
    c_ld = 1'b1; c_mode = 3'b011; c_d = 8'hFF; step();
    c_ld = 1'b0; c_mode = 3'b100; #1;
    check("cas_tc_lo", {31'd0, tc_lo}, 32'd1);
    check("cas_tc_hi", {31'd0, tc_hi}, 32'd1);
    step();
    check("cas_ff_00", {24'd0, q_hi, q_lo}, 32'h00);

    // reset mid-operation on the RESET_VAL=0x15 part
    clr_b = 1'b0;
    mode = 3'b011; d6 = 6'h07; step();
    check("rb_load", {26'd0, q_b}, 32'h07);
    mode = 3'b100; step();
    check("rb_cnt", {26'd0, q_b}, 32'h08);
    #3 clr_b = 1'b1;
    #1 check("rb_clr_async", {26'd0, q_b}, 32'h15);
    check("rb_clr_tc", {31'd0, tc_b}, 32'd0);
    step();
    check("rb_clr_edge", {26'd0, q_b}, 32'h15);
    clr_b = 1'b0;
    step();
    check("rb_release", {26'd0, q_b}, 32'h16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard bound on run length
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
